// File: rtl/count_disp_pkg.sv
// rtl/count_disp_pkg.sv - shared types, constants and the double-dabble step for count_bcd_display
package count_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_W  = 12;
  localparam int ITER_N = 8;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One double-dabble iteration on {hundreds,tens,units,binary}: correct nibbles >=5, shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// rtl/seven_seg_decode.sv - BCD nibble to active-high {g,f,e,d,c,b,a}; non-decimal codes go dark
module seven_seg_decode
  import count_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - sequential binary-to-BCD converter driving a 3-digit multiplexed display
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       count_in,
  input  logic             sample,
  output logic             ready,
  output logic [BCD_W-1:0] bcd_out,
  output logic             bcd_valid,
  output logic [6:0]       seg,
  output logic [2:0]       dig_sel
);

  localparam int             CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]     ITER_LAST = 4'(ITER_N - 1);

  state_t             state, state_nxt;
  logic [19:0]        shreg;
  logic [3:0]         iter;
  logic [CNT_W-1:0]   scan_cnt;
  logic [1:0]         idx, idx_nxt;
  logic [BCD_W-1:0]   disp_nxt;
  logic [3:0]         nib;
  logic [6:0]         seg_dec, seg_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = CONV;
      CONV:    if (iter == ITER_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      shreg     <= '0;
      iter      <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ready     <= (state_nxt == IDLE);
      bcd_valid <= (state == DONE);
      case (state)
        IDLE: if (sample) begin
          shreg <= {12'h000, count_in};
          iter  <= '0;
        end
        CONV: begin
          shreg <= dabble_step(shreg);
          iter  <= iter + 4'd1;
        end
        DONE:    bcd_out <= shreg[19:8];
        default: ;
      endcase
    end
  end

  // bcd_out doubles as the display register; seg is decoded from the values that will be
  // current after this edge so seg, dig_sel and a fresh result all switch together.
  always_comb begin
    disp_nxt = (state == DONE) ? shreg[19:8] : bcd_out;
    idx_nxt  = idx;
    if (scan_cnt == CNT_LAST) idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    case (idx_nxt)
      2'd1:    nib = disp_nxt[7:4];
      2'd2:    nib = disp_nxt[11:8];
      default: nib = disp_nxt[3:0];
    endcase
  end

  seven_seg_decode u_decode (
    .nibble (nib),
    .seg    (seg_dec)
  );

  always_comb begin
    seg_nxt = seg_dec;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_nxt == 2'd2 && disp_nxt[11:8] == 4'd0) seg_nxt = SEG_BLANK;
    if (idx_nxt == 2'd1 && disp_nxt[11:4] == 8'd0) seg_nxt = SEG_BLANK;
`else
    seg_nxt = seg_dec;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      seg      <= SEG_0;
      dig_sel  <= 3'b001;
    end else begin
      scan_cnt <= (scan_cnt == CNT_LAST) ? '0 : scan_cnt + 1'b1;
      idx      <= idx_nxt;
      seg      <= seg_nxt;
      dig_sel  <= 3'b001 << idx_nxt;
    end
  end

endmodule
